// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;
  localparam int BIDX_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // States in which the loader consumes bytes from the stream.
  function automatic logic takes_bytes(input state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles four bytes little-endian into a 32-bit word and pulses
// word_valid_o for one cycle after the fourth byte.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic [BIDX_W-1:0] byte_idx_o,
  output logic [31:0]       word_o,
  output logic              word_valid_o
);

  logic [BIDX_W-1:0] cnt_q, cnt_d;
  logic [23:0]       lo_q, lo_d;
  logic [31:0]       word_q, word_d;
  logic              valid_q, valid_d;

  // Lower three bytes wait in lo_q; the fourth byte completes the word.
  always_comb begin
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
      lo_d  = '0;
    end else if (byte_en_i) begin
      case (cnt_q)
        2'd0: lo_d[7:0]   = byte_i;
        2'd1: lo_d[15:8]  = byte_i;
        2'd2: lo_d[23:16] = byte_i;
        default: begin
          word_d  = {byte_i, lo_q};
          valid_d = 1'b1;
        end
      endcase
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      lo_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign byte_idx_o   = cnt_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes it word by word into instruction memory and releases the core on success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = (2 ** ADDR_W) / 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] words_loaded
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-2:0] words_q, words_d;

  logic              accept;
  logic              pk_clear;
  logic              pk_en;
  logic [BIDX_W-1:0] pk_idx;
  logic [31:0]       pk_word;
  logic              pk_valid;
  logic [LEN_W-1:0]  len_full;
  logic              last_word;
  logic              last_byte;

  assign accept    = byte_valid && byte_ready;
  assign pk_en     = accept && (state_q == DATA);
  assign len_full  = {byte_in, len_q[7:0]};
  assign last_byte = (pk_idx == BIDX_W'(WORD_BYTES - 1));
  // words_q already counts every earlier word: their write strobes land
  // well before the next word's fourth byte arrives.
  assign last_word = ((LEN_W'(words_q) + LEN_W'(1)) == len_q);

  word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clear),
    .byte_en_i    (pk_en),
    .byte_i       (byte_in),
    .byte_idx_o   (pk_idx),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    csum_d   = csum_q;
    words_d  = words_q;
    pk_clear = 1'b0;

    if (pk_valid && (words_q != (ADDR_W - 1)'(MAX_WORDS))) begin
      words_d = words_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d  = LEN_LO;
          len_d    = '0;
          csum_d   = '0;
          words_d  = '0;
          pk_clear = 1'b1;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_in;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_full;
          if (len_full > LEN_W'(MAX_WORDS)) begin
            state_d = ERR;
          end else if (len_full == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ byte_in;
          if (last_byte && last_word) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (byte_in == csum_q) ? DONE : ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      csum_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      words_q <= words_d;
    end
  end

  assign byte_ready   = takes_bytes(state_q);
  assign busy         = byte_ready;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign core_reset   = (state_q != DONE);
  assign mem_we       = pk_valid;
  assign mem_addr     = {words_q[ADDR_W-3:0], 2'b00};
  assign mem_wdata    = pk_word;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: spec vectors, corner-case sequences
// and randomized loads checked against a byte-stream reference model.
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 64;

  typedef logic [7:0] byteQ_t[$];

  typedef struct {
    string        name;
    logic [127:0] bits;
    int           n;
    int           expDone;
    int           expErr;
    int           expWords;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-2:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wrAddr[$];
  logic [31:0]       wrData[$];
  logic [ADDR_W-1:0] expAddr[$];
  logic [31:0]       expData[$];
  int                expDone, expError, expWords;
  vec_t              vecs[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Capture every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    logic accepted;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    accepted   = 1'b0;
    for (int w = 0; w < 50 && !accepted; w++) begin
      @(negedge clk);
      accepted = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: byte 0x%0h got ready=0, required ready=1", b);
    end
  endtask

  // gapMode 0: back-to-back, 1: idle cycle before every other byte, 2: random gaps.
  task automatic applyStimulus(input byteQ_t s, input int gapMode);
    int gap;
    wrAddr.delete();
    wrData.delete();
    pulseStart();
    foreach (s[i]) begin
      gap = (gapMode == 0) ? 0 : (gapMode == 1) ? (i % 2) : int'($urandom_range(3, 0));
      sendByte(s[i], gap);
    end
    @(negedge clk);
  endtask

  // Reference: parse the stream as length, words and checksum byte.
  task automatic modelLoad(input byteQ_t s);
    int          len;
    logic [7:0]  x;
    logic [31:0] w;
    expAddr.delete();
    expData.delete();
    len = int'(s[0]) + 256 * int'(s[1]);
    if (len > MAX_WORDS) begin
      expDone = 0; expError = 1; expWords = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w = w | (32'(s[2 + 4 * i + k]) << (8 * k));
        x = x ^ s[2 + 4 * i + k];
      end
      expAddr.push_back(ADDR_W'(4 * i));
      expData.push_back(w);
    end
    expWords = len;
    expDone  = (s[2 + 4 * len] == x) ? 1 : 0;
    expError = 1 - expDone;
  endtask

  task automatic checkLoad(input byteQ_t s, input string tag);
    modelLoad(s);
    checkOutput({tag, " done"},         64'(done),         64'(expDone));
    checkOutput({tag, " error"},        64'(error),        64'(expError));
    checkOutput({tag, " core_reset"},   64'(core_reset),   64'(1 - expDone));
    checkOutput({tag, " words_loaded"}, 64'(words_loaded), 64'(expWords));
    checkOutput({tag, " busy"},         64'(busy),         64'(0));
    checkOutput({tag, " byte_ready"},   64'(byte_ready),   64'(0));
    checkOutput({tag, " write_count"},  64'(wrAddr.size()), 64'(expAddr.size()));
    for (int i = 0; i < expAddr.size() && i < wrAddr.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(wrAddr[i]), 64'(expAddr[i]));
      checkOutput($sformatf("%s data[%0d]", tag, i), 64'(wrData[i]), 64'(expData[i]));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " byte_ready"},   64'(byte_ready),   64'(0));
    checkOutput({tag, " mem_we"},       64'(mem_we),       64'(0));
    checkOutput({tag, " mem_addr"},     64'(mem_addr),     64'(0));
    checkOutput({tag, " mem_wdata"},    64'(mem_wdata),    64'(0));
    checkOutput({tag, " core_reset"},   64'(core_reset),   64'(1));
    checkOutput({tag, " busy"},         64'(busy),         64'(0));
    checkOutput({tag, " done"},         64'(done),         64'(0));
    checkOutput({tag, " error"},        64'(error),        64'(0));
    checkOutput({tag, " words_loaded"}, 64'(words_loaded), 64'(0));
  endtask

  function automatic byteQ_t toQueue(input logic [127:0] bits, input int n);
    byteQ_t q;
    for (int i = 0; i < n; i++) q.push_back(bits[8 * (n - 1 - i) +: 8]);
    return q;
  endfunction

  task automatic addVec(input string name, input logic [127:0] bits, input int n,
                        input int d, input int e, input int w);
    vec_t v;
    v.name = name; v.bits = bits; v.n = n;
    v.expDone = d; v.expErr = e; v.expWords = w;
    vecs.push_back(v);
  endtask

  initial begin
    byteQ_t good2, q;
    int     len;
    logic [7:0] x, b;

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    good2 = toQueue(128'h02_00_13_05_10_00_93_05_20_00_B0, 11);

    addVec("good2",     128'h02_00_13_05_10_00_93_05_20_00_B0, 11, 1, 0, 2);
    addVec("badcsum",   128'h02_00_13_05_10_00_93_05_20_00_00, 11, 0, 1, 2);
    addVec("recover",   128'h02_00_13_05_10_00_93_05_20_00_B0, 11, 1, 0, 2);
    addVec("oversize",  128'h41_00,                             2,  0, 1, 0);
    addVec("len256",    128'h00_01,                             2,  0, 1, 0);
    addVec("zero",      128'h00_00_00,                          3,  1, 0, 0);
    addVec("zerobad",   128'h00_00_5A,                          3,  0, 1, 0);
    addVec("oneword",   128'h01_00_AA_BB_CC_DD_00,              7,  1, 0, 1);

    foreach (vecs[v]) begin
      q = toQueue(vecs[v].bits, vecs[v].n);
      applyStimulus(q, 0);
      checkOutput({vecs[v].name, " tbl_done"},  64'(done),           64'(vecs[v].expDone));
      checkOutput({vecs[v].name, " tbl_error"}, 64'(error),          64'(vecs[v].expErr));
      checkOutput({vecs[v].name, " tbl_words"}, 64'(words_loaded),   64'(vecs[v].expWords));
      checkOutput({vecs[v].name, " tbl_nwr"},   64'(wrAddr.size()),  64'(vecs[v].expWords));
      checkLoad(q, vecs[v].name);
    end

    $display("[TB] backpressure sequences");
    for (int mode = 1; mode <= 2; mode++) begin
      applyStimulus(good2, mode);
      checkOutput("gaps nwr", 64'(wrData.size()), 64'(2));
      if (wrData.size() == 2) begin
        checkOutput("gaps addr0", 64'(wrAddr[0]), 64'h00);
        checkOutput("gaps data0", 64'(wrData[0]), 64'h00100513);
        checkOutput("gaps addr1", 64'(wrAddr[1]), 64'h04);
        checkOutput("gaps data1", 64'(wrData[1]), 64'h00200593);
      end
      checkOutput("gaps done", 64'(done), 64'(1));
    end

    $display("[TB] restart from DONE clears status");
    pulseStart();
    @(negedge clk);
    checkOutput("restart done",  64'(done),         64'(0));
    checkOutput("restart words", 64'(words_loaded), 64'(0));
    checkOutput("restart busy",  64'(busy),         64'(1));
    checkOutput("restart corer", 64'(core_reset),   64'(1));
    @(posedge clk); #1;
    sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    @(negedge clk);
    checkOutput("restart zero done", 64'(done), 64'(1));

    $display("[TB] reset in the middle of a load");
    wrAddr.delete(); wrData.delete();
    pulseStart();
    sendByte(8'h02, 0); sendByte(8'h00, 0); sendByte(8'h13, 0); sendByte(8'h05, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("midreset");
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midreset no_write", 64'(wrAddr.size()), 64'(0));
    applyStimulus(good2, 0);
    checkLoad(good2, "after_reset");

    $display("[TB] start pulse during DATA is ignored");
    wrAddr.delete(); wrData.delete();
    pulseStart();
    for (int i = 0; i < 6; i++) sendByte(good2[i], 0);
    pulseStart();
    checkOutput("midstart busy", 64'(busy), 64'(1));
    for (int i = 6; i < 11; i++) sendByte(good2[i], 0);
    @(negedge clk);
    checkLoad(good2, "midstart");

    $display("[TB] randomized loads");
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(9, 0))
        9:       len = MAX_WORDS;
        8:       len = MAX_WORDS + 1 + int'($urandom_range(300, 0));
        default: len = int'($urandom_range(6, 0));
      endcase
      q.delete();
      q.push_back(8'(len));
      q.push_back(8'(len >> 8));
      if (len <= MAX_WORDS) begin
        x = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
          b = 8'($urandom);
          x = x ^ b;
          q.push_back(b);
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
        q.push_back(x);
      end
      applyStimulus(q, int'($urandom_range(2, 0)));
      checkLoad(q, $sformatf("rand%0d len%0d", t, len));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory. The core fetches from that memory as a read-only port.
- Accepts a byte stream over a valid/ready handshake: 16-bit little-endian word count, then instruction bytes, then a checksum byte.
- Packs the bytes into 32-bit little-endian words and writes them to sequential word-aligned addresses.
- Holds the core in reset until a load completes with a good checksum.

Parameters:
- ADDR_W, 8, byte-address width of the instruction memory (matches the 8-bit PC).
- MAX_WORDS, 2**ADDR_W/4 (=64), largest legal word count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that begins a load
- byte_in  input  8  stream data
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  ADDR_W  byte address of the write, always a multiple of 4
- mem_wdata  output  32  instruction word
- core_reset  output  1  hold the core in reset
- busy  output  1  load in progress
- done  output  1  load finished with a good checksum
- error  output  1  load aborted (bad length or bad checksum)
- words_loaded  output  ADDR_W-1  count of words written in the current load

Behaviour:
- Interface: clk is the single clock. reset is synchronous and active-high.
- Reset values: state IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, busy=0, done=0, error=0, words_loaded=0. Internal checksum and counters cleared.
- Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is registered-state-driven and high only in LEN_LO, LEN_HI, DATA and CSUM.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: start -> LEN_LO.
- LEN_LO: accept -> store len[7:0] -> LEN_HI.
- LEN_HI: accept -> store len[15:8].
  - len > MAX_WORDS -> ERR.
  - len == 0 -> CSUM.
  - otherwise -> DATA.
- DATA: bytes are assembled little-endian; byte 0 goes to [7:0], byte 3 to [31:24].
  - A 2-bit byte counter wraps after the 4th byte.
  - The cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle, mem_addr = word_idx*4, mem_wdata = assembled word, and words_loaded increments.
  - After the last word's 4th byte -> CSUM.
  - byte_ready remains high during the mem_we cycle, so back-to-back bytes sustain one byte per cycle.
- Checksum: XOR of all data bytes only; the length bytes are excluded.
- CSUM: accept -> compare the received byte to the running XOR. Match -> DONE; mismatch -> ERR.
  - The final word's mem_we is guaranteed to occur before or in the same cycle as the DONE/ERR transition.
- DONE: done=1, core_reset=0. start -> LEN_LO, clearing done, words_loaded and the checksum.
- ERR: error=1 (sticky), core_reset=1. start -> LEN_LO, clearing error.
- core_reset=1 in every state except DONE. busy=1 in LEN_LO, LEN_HI, DATA and CSUM.
- start is ignored in LEN_LO, LEN_HI, DATA and CSUM.
- Words already written before an ERR are not rolled back.
- reset mid-load: returns to IDLE next edge with all reset values. A partially assembled word is discarded and never written.
- words_loaded saturates at MAX_WORDS; the length check guarantees it is never exceeded.
- Address wrap: impossible, because len <= MAX_WORDS bounds word_idx*4 to at most 2**ADDR_W-4.

Decomposition:
- Package imem_loader_pkg holds:
  - state_t enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR)
  - LEN_W=16
  - WORD_BYTES=4
- One sub-module, word_packer, takes byte, byte_en and clear, and outputs word[31:0] and word_valid (a one-cycle pulse after the 4th byte).
- The top level holds the FSM, the address/count registers and the XOR checksum.

Test Plan:
- Two-word load: start, then stream 02 00 13 05 10 00 93 05 20 00 B0 -> writes (0x00,0x00100513) and (0x04,0x00200593); done=1, core_reset=0, words_loaded=2, error=0.
- Bad checksum: same stream with final byte 00 -> both writes occur, then error=1, done=0, core_reset=1. A following start with the good stream -> done=1.
- Oversize length: stream 41 00 (65) -> ERR in the cycle after LEN_HI accept, no mem_we, byte_ready=0, error=1.
- Backpressure/gaps: the two-word stream with byte_valid toggling every other cycle and random idle gaps -> identical writes, identical addresses, done=1. Exactly 2 mem_we pulses.
- Reset mid-load: assert reset after accepting 02 00 13 05 -> next cycle all outputs at reset values, no mem_we ever issued. A subsequent full load succeeds.
- Zero length: stream 00 00 00 -> no writes, done=1, words_loaded=0, core_reset=0. A start issued during DATA in any load is ignored.
